// File: rtl/adder_result_fifo_if.sv
// adder_result_fifo_if
//   Valid/allow stream carrying one adder result {res, cout}.
//   master : drives valid/res/cout, samples allow
//   slave  : samples valid/res/cout, drives allow
//   A beat transfers on a rising clock edge where valid && allow.
interface adder_result_fifo_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             allow;

    modport master (output valid, output res, output cout, input allow);
    modport slave  (input valid, input res, input cout, output allow);
endinterface

// File: rtl/adder_result_fifo.sv
// adder_result_fifo
//   In-order result buffer placed after the 4-stage pipelined adder. It takes
//   {res,cout} on the adder's valid/allow handshake and re-presents it to the
//   consumer on the same handshake, so consumer back-pressure never reaches
//   the adder's last stage combinationally.
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   flush    synchronous flush, active-low; empties the FIFO, keeps acc_cnt
//   in_if    slave stream from the adder (valid/res/cout in, allow out)
//   out_if   master stream to the consumer (valid/res/cout out, allow in)
//   count    number of stored entries
//   full     count == DEPTH
//   empty    count == 0
//   acc_cnt  results accepted since reset (wraps)
module adder_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    adder_result_fifo_if.slave         in_if,
    adder_result_fifo_if.master        out_if,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [CNTW-1:0]            acc_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] mem [DEPTH];    // {cout, res}

    logic push;
    logic pop;

    // Status comes only from the registered count, so in_allow has no
    // combinational dependency on the consumer's allow.
    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign count        = cnt;
    assign in_if.allow  = !full;
    assign out_if.valid = !empty;
    assign out_if.res   = mem[rd_ptr][WIDTH-1:0];
    assign out_if.cout  = mem[rd_ptr][WIDTH];

    assign push = in_if.valid && in_if.allow;
    assign pop  = out_if.valid && out_if.allow;

    // Pointers are AW bits wide and DEPTH is a power of two, so increment
    // wraps modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (!flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is intentionally not reset; a flushed push must not write
    // either, though a stale write would be harmless since count is zeroed.
    always_ff @(posedge clk) begin
        if (flush && push) mem[wr_ptr] <= {in_if.cout, in_if.res};
    end

    // Accepted-result counter survives flush; a push discarded by flush
    // is not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              acc_cnt <= '0;
        else if (flush && push) acc_cnt <= acc_cnt + 1'b1;
    end
endmodule
